// File: rtl/sound_pkg.sv
// Shared types and constants for the buzzer arbiter and its pattern ROM.
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_t;

  localparam int NOTE_W  = 5;
  localparam int DUR_W   = 5;
  localparam int STEP_W  = 2;
  localparam int PAT_W   = 2;
  localparam int NUM_REQ = 4;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd31;
  localparam logic [STEP_W-1:0] STEP_LAST = '1;

  localparam logic [PAT_W-1:0] REQ_STONE   = 2'd0;
  localparam logic [PAT_W-1:0] REQ_CAPTURE = 2'd1;
  localparam logic [PAT_W-1:0] REQ_ILLEGAL = 2'd2;
  localparam logic [PAT_W-1:0] REQ_ALARM   = 2'd3;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  // Highest set index wins; returns 0 for an empty vector.
  function automatic logic [PAT_W-1:0] highest_index(input logic [NUM_REQ-1:0] vec);
    highest_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vec[i]) highest_index = PAT_W'(i);
    end
  endfunction

endpackage

// File: rtl/sound_pattern_rom.sv
// Fixed sound patterns: (pattern, step) -> {note_id, dur}; dur = 0 ends a pattern.
module sound_pattern_rom
  import sound_pkg::*;
(
  input  logic [PAT_W-1:0]  pattern,
  input  logic [STEP_W-1:0] step,
  output rom_entry_t        entry
);

  always_comb begin
    entry = {NOTE_REST, 5'd0};
    case (pattern)
      REQ_STONE: begin
        if (step == 2'd0) entry = {5'd21, 5'd5};
      end
      REQ_CAPTURE: begin
        case (step)
          2'd0:    entry = {5'd16, 5'd4};
          2'd1:    entry = {5'd21, 5'd4};
          default: entry = {NOTE_REST, 5'd0};
        endcase
      end
      REQ_ILLEGAL: begin
        case (step)
          2'd0:    entry = {5'd0, 5'd10};
          2'd1:    entry = {NOTE_REST, 5'd5};
          2'd2:    entry = {5'd0, 5'd10};
          default: entry = {NOTE_REST, 5'd0};
        endcase
      end
      REQ_ALARM: begin
        case (step)
          2'd0:    entry = {5'd12, 5'd8};
          2'd1:    entry = {5'd16, 5'd8};
          2'd2:    entry = {5'd19, 5'd8};
          default: entry = {5'd23, 5'd20};
        endcase
      end
      default: entry = {NOTE_REST, 5'd0};
    endcase
  end

endmodule

// File: rtl/sound_arbiter.sv
// Priority arbiter for the shared buzzer: latches request pulses, plays one
// ROM pattern at a time with a silent gap, alarm preempts, mute silences.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int TICK_DIV  = 10000,
  parameter int GAP_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic              mute,
  output logic              tone_en,
  output logic [NOTE_W-1:0] note_id,
  output logic [3:0]        grant,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_TICKS);

  state_t             state, state_n;
  logic [3:0]         pending, pending_n, grant_clr;
  logic [PAT_W-1:0]   owner, owner_n, rom_pat;
  logic [STEP_W-1:0]  step, step_n, rom_step;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [DUR_W-1:0]   dur_cnt, dur_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic [NOTE_W-1:0]  note_n;
  logic [3:0]         grant_n;
  logic               tone_n, done_n, aborted_n;
  logic               tick, preempt;
  rom_entry_t         rom_q;

  // One ROM port: step 0 of the pattern being started, else the step after the current one.
  always_comb begin
    tick    = (presc == PRESC_MAX);
    preempt = pending[REQ_ALARM] && (state != ST_IDLE) && (owner != REQ_ALARM);
    if (preempt) begin
      rom_pat  = REQ_ALARM;
      rom_step = '0;
    end else if (state == ST_IDLE) begin
      rom_pat  = highest_index(pending);
      rom_step = '0;
    end else begin
      rom_pat  = owner;
      rom_step = step + 1'b1;
    end
  end

  sound_pattern_rom u_rom (
    .pattern (rom_pat),
    .step    (rom_step),
    .entry   (rom_q)
  );

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_n   = state;
    owner_n   = owner;
    step_n    = step;
    presc_n   = (state == ST_IDLE || tick) ? '0 : presc + 1'b1;
    dur_n     = dur_cnt;
    gap_n     = gap_cnt;
    note_n    = note_id;
    tone_n    = tone_en;
    grant_n   = grant;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    grant_clr = '0;

    if (mute) begin
      state_n   = ST_IDLE;
      step_n    = '0;
      presc_n   = '0;
      dur_n     = '0;
      gap_n     = '0;
      note_n    = NOTE_REST;
      tone_n    = 1'b0;
      grant_n   = '0;
      aborted_n = (state == ST_PLAY);
    end else if (preempt || (state == ST_IDLE && pending != '0)) begin
      owner_n   = rom_pat;
      step_n    = '0;
      presc_n   = '0;
      grant_n   = 4'b0001 << rom_pat;
      grant_clr = grant_n;
      aborted_n = preempt && (state == ST_PLAY);
      if (rom_q.dur == '0) begin
        state_n = ST_GAP;
        gap_n   = GAP_LOAD;
        dur_n   = '0;
        note_n  = NOTE_REST;
        tone_n  = 1'b0;
        done_n  = 1'b1;
      end else begin
        state_n = ST_PLAY;
        dur_n   = rom_q.dur;
        note_n  = rom_q.note;
        tone_n  = (rom_q.note != NOTE_REST);
      end
    end else if (state == ST_PLAY && tick) begin
      if (dur_cnt > 5'd1) begin
        dur_n = dur_cnt - 1'b1;
      end else if (step == STEP_LAST || rom_q.dur == '0) begin
        state_n = ST_GAP;
        gap_n   = GAP_LOAD;
        dur_n   = '0;
        note_n  = NOTE_REST;
        tone_n  = 1'b0;
        done_n  = 1'b1;
      end else begin
        step_n = step + 1'b1;
        dur_n  = rom_q.dur;
        note_n = rom_q.note;
        tone_n = (rom_q.note != NOTE_REST);
      end
    end else if (state == ST_GAP && tick) begin
      if (gap_cnt > GAP_W'(1)) begin
        gap_n = gap_cnt - 1'b1;
      end else begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    end

    // A request arriving with its own grant re-arms the bit.
    pending_n = mute ? '0 : ((pending & ~grant_clr) | req);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
      owner   <= '0;
      step    <= '0;
      presc   <= '0;
      dur_cnt <= '0;
      gap_cnt <= '0;
      tone_en <= 1'b0;
      note_id <= NOTE_REST;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      owner   <= owner_n;
      step    <= step_n;
      presc   <= presc_n;
      dur_cnt <= dur_n;
      gap_cnt <= gap_n;
      tone_en <= tone_n;
      note_id <= note_n;
      grant   <= grant_n;
      busy    <= (state_n != ST_IDLE);
      done    <= done_n;
      aborted <= aborted_n;
    end
  end

endmodule
